mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/mmio_uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the memory-mapped UART transmitter.
//
// Holds the register offsets (addr[3:2] word index), the STATUS bit
// positions, the transmit FSM state encoding and a helper that packs the
// STATUS word. Imported by mmio_uart_tx.
package uart_pkg;

  // Word index of each register (addr[3:2]).
  localparam logic [1:0] REG_TXDATA = 2'd0;  // 0x0, write-only byte push
  localparam logic [1:0] REG_STATUS = 2'd1;  // 0x4, read / write-1-to-clear
  localparam logic [1:0] REG_COUNT  = 2'd2;  // 0x8, FIFO occupancy
  localparam logic [1:0] REG_RSVD   = 2'd3;  // 0xC, reads zero

  // STATUS bit positions.
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // Transmit FSM encoding.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Pack the STATUS word; all bits above STAT_OVF read as zero.
  function automatic logic [31:0] status_word(input logic ovf, input logic busy,
                                              input logic empty, input logic full);
    logic [31:0] w;
    w             = 32'd0;
    w[STAT_FULL]  = full;
    w[STAT_EMPTY] = empty;
    w[STAT_BUSY]  = busy;
    w[STAT_OVF]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock first-word-fall-through FIFO.
//
// Parameters: DEPTH (power of two, >= 2), WIDTH (data bits).
// Ports:
//   clk, rst        clock, asynchronous active-high reset (empties FIFO)
//   push, wdata     write request and data; accepted when not full, or when
//                   full and a pop happens in the same cycle
//   pop             read request; ignored when empty
//   rdata           head entry (valid whenever empty=0)
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;
  assign rdata = mem[rd_ptr_r];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx -- memory-mapped 8N1 UART transmitter with a TX byte FIFO.
//
// Parameters: FIFO_DEPTH (power of two, 2..256), CLKS_PER_BIT (>= 2).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   sel, we      bus access strobe for this block, store (1) / load (0)
//   addr         byte offset; bits [3:2] select TXDATA/STATUS/COUNT/reserved
//   wdata        store data
//   rdata        load data, combinational; zero when sel=0
//   tx           registered serial output, idle high
//   irq          high while the FIFO is empty and the transmitter is idle
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_t     state_r;
  logic [BW-1:0] baud_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic          tx_r;
  logic          ovf_r;

  logic [1:0]    reg_idx;
  logic          txdata_wr;
  logic          status_wr;
  logic          fifo_pop;
  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          baud_done;
  logic          busy;
  logic          unused_bits;

  assign reg_idx   = addr[3:2];
  assign txdata_wr = sel && we && (reg_idx == REG_TXDATA);
  assign status_wr = sel && we && (reg_idx == REG_STATUS) && wdata[STAT_OVF];
  assign baud_done = (baud_cnt_r == BAUD_LAST);
  assign busy      = (state_r != TX_IDLE);
  assign tx        = tx_r;
  assign irq       = fifo_empty && !busy;

  // Byte-lane offset bits and upper store data carry no meaning here.
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (txdata_wr),
    .pop   (fifo_pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Pop request: the FSM takes a byte when leaving IDLE or at the end of STOP.
  always_comb begin
    fifo_pop = 1'b0;
    if (state_r == TX_IDLE) begin
      fifo_pop = !fifo_empty;
    end else if ((state_r == TX_STOP) && baud_done) begin
      fifo_pop = !fifo_empty;
    end else begin
      fifo_pop = 1'b0;
    end
  end

  // Sticky overflow: a store that finds the FIFO full with no pop is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (txdata_wr && fifo_full && !fifo_pop) begin
      ovf_r <= 1'b1;
    end else if (status_wr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Transmit FSM; tx is updated on the same edge as the state so it never glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= TX_IDLE;
      baud_cnt_r <= {BW{1'b0}};
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'd0;
      tx_r       <= 1'b1;
    end else begin
      case (state_r)
        TX_IDLE: begin
          baud_cnt_r <= {BW{1'b0}};
          bit_idx_r  <= 3'd0;
          if (fifo_pop) begin
            state_r <= TX_START;
            shift_r <= fifo_rdata;
            tx_r    <= 1'b0;
          end else begin
            tx_r    <= 1'b1;
          end
        end
        TX_START: begin
          if (baud_done) begin
            baud_cnt_r <= {BW{1'b0}};
            bit_idx_r  <= 3'd0;
            state_r    <= TX_DATA;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_cnt_r <= {BW{1'b0}};
            if (bit_idx_r == 3'd7) begin
              state_r <= TX_STOP;
              tx_r    <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            baud_cnt_r <= {BW{1'b0}};
            bit_idx_r  <= 3'd0;
            // Chaining straight into START keeps back-to-back frames gapless.
            if (fifo_pop) begin
              state_r <= TX_START;
              shift_r <= fifo_rdata;
              tx_r    <= 1'b0;
            end else begin
              state_r <= TX_IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
          end
        end
        default: begin
          state_r    <= TX_IDLE;
          baud_cnt_r <= {BW{1'b0}};
          bit_idx_r  <= 3'd0;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

  // Load data mux; loads have no side effects and an unselected bus reads zero.
  always_comb begin
    rdata = 32'd0;
    if (sel) begin
      case (reg_idx)
        REG_STATUS: rdata = status_word(ovf_r, busy, fifo_empty, fifo_full);
        REG_COUNT:  rdata = {{(32 - CW){1'b0}}, fifo_count};
        REG_TXDATA: rdata = 32'd0;
        REG_RSVD:   rdata = 32'd0;
        default:    rdata = 32'd0;
      endcase
    end else begin
      rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx -- self-checking bench for mmio_uart_tx (FIFO_DEPTH=4,
// CLKS_PER_BIT=4). Stores push expected bytes into a scoreboard queue; a
// line monitor decodes every frame on tx and compares it sample-by-sample
// against the frame built from the popped byte.
module tb_mmio_uart_tx;

  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] sb [$];
  int frames_done    = 0;
  int frames_started = 0;
  int last_gap       = 0;
  int idle_run       = 0;
  bit in_frame       = 1'b0;

  mmio_uart_tx #(
    .FIFO_DEPTH   (DEPTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Line monitor: samples tx on every falling edge and checks whole frames.
  initial begin : line_monitor
    logic [FRAME-1:0] cap;
    logic [FRAME-1:0] expv;
    logic [7:0]       eb;
    int               idx;
    cap  = '0;
    expv = '0;
    eb   = 8'h00;
    idx  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
        idle_run = 0;
      end else if (!in_frame) begin
        if (tx === 1'b0) begin
          in_frame = 1'b1;
          frames_started++;
          last_gap = idle_run;
          idle_run = 0;
          cap = '0;
          idx = 1;
          if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_frame: start bit seen at %0t, required idle line", $time);
            eb = 8'h00;
          end else begin
            eb = sb.pop_front();
          end
        end else begin
          idle_run++;
        end
      end else begin
        cap[idx] = tx;
        idx++;
        if (idx == FRAME) begin
          for (int j = 0; j < FRAME; j++) begin
            int b;
            b = j / CPB;
            if (b == 0)      expv[j] = 1'b0;
            else if (b == 9) expv[j] = 1'b1;
            else             expv[j] = eb[b-1];
          end
          tests_run++;
          if (cap !== expv) begin
            tests_failed++;
            $display("FAIL frame_%02h: got %b required %b", eb, cap, expv);
          end
          frames_done++;
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [31:0] d);
    tick();
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [31:0] d);
    tick();
    sel = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    sel = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (sb.size() == 0 && !in_frame && irq === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) tick();
    tests_run++;
    if (tx !== 1'b1 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_outputs: got tx=%b irq=%b required tx=1 irq=1", tx, irq);
    end
    rst = 1'b0;
    cpu_read(4'h4, d);
    tests_run++;
    if (d !== 32'h2) begin
      tests_failed++;
      $display("FAIL reset_status: got %h required %h", d, 32'h2);
    end
    cpu_read(4'h8, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_count: got %h required %h", d, 32'h0);
    end
    tick();
    sel = 1'b0; addr = 4'h4;
    #1;
    tests_run++;
    if (rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_unselected: got %h required %h", rdata, 32'h0);
    end
  endtask

  task automatic test_single_frame();
    int f0;
    f0 = frames_done;
    sb.push_back(8'h41);
    cpu_write(4'h0, 32'h0000_0041);
    tests_run++;
    if (tx !== 1'b1 || irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_after_push: got tx=%b irq=%b required tx=1 irq=0", tx, irq);
    end
    tick();
    tests_run++;
    if (tx !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_start_latency: got tx=%b required 0", tx);
    end
    repeat (39) tick();
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_irq_in_stop: got %b required 0", irq);
    end
    tick();
    tests_run++;
    if (irq !== 1'b1 || tx !== 1'b1 || frames_done !== f0 + 1) begin
      tests_failed++;
      $display("FAIL single_done: got irq=%b tx=%b frames=%0d required irq=1 tx=1 frames=%0d",
               irq, tx, frames_done, f0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int f0;
    bit ok;
    f0 = frames_done;
    sb.push_back(8'h55);
    cpu_write(4'h0, 32'h0000_0055);
    sb.push_back(8'hAA);
    cpu_write(4'h0, 32'h0000_00AA);
    cpu_read(4'h8, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL b2b_count_first: got %h required %h", d, 32'h1);
    end
    for (int i = 0; i < 200; i++) begin
      tick();
      if (frames_done != f0) break;
    end
    tick();
    cpu_read(4'h8, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL b2b_count_second: got %h required %h", d, 32'h0);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok || frames_done !== f0 + 2 || last_gap !== 0) begin
      tests_failed++;
      $display("FAIL b2b_gap: got ok=%0d frames=%0d gap=%0d required ok=1 frames=%0d gap=0",
               ok, frames_done - f0, last_gap, 2);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 1; i <= 6; i++) begin
      logic [7:0] b;
      b = 8'(i * 17);
      if (i <= 5) sb.push_back(b);
      cpu_write(4'h0, {24'h0, b});
    end
    cpu_read(4'h4, d);
    tests_run++;
    if (d !== 32'hD) begin
      tests_failed++;
      $display("FAIL ovf_status: got %h required %h", d, 32'hD);
    end
    cpu_read(4'h8, d);
    tests_run++;
    if (d !== 32'h4) begin
      tests_failed++;
      $display("FAIL ovf_count: got %h required %h", d, 32'h4);
    end
    cpu_write(4'h4, 32'h0000_0008);
    cpu_read(4'h4, d);
    tests_run++;
    if (d !== 32'h5) begin
      tests_failed++;
      $display("FAIL ovf_clear: got %h required %h", d, 32'h5);
    end
  endtask

  task automatic test_full_pop_edge();
    logic [31:0] d;
    int f0;
    bit ok;
    f0 = frames_done;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (frames_done != f0) break;
    end
    // Last stop-bit cycle is in progress: this store lands on the pop edge.
    sel = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'h0000_0077;
    sb.push_back(8'h77);
    tick();
    sel = 1'b0; we = 1'b0;
    cpu_read(4'h8, d);
    tests_run++;
    if (d !== 32'h4) begin
      tests_failed++;
      $display("FAIL popedge_count: got %h required %h", d, 32'h4);
    end
    cpu_read(4'h4, d);
    tests_run++;
    if (d !== 32'h5) begin
      tests_failed++;
      $display("FAIL popedge_status: got %h required %h", d, 32'h5);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL popedge_drain: got queued=%0d required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    int fs;
    sb.push_back(8'h00);
    cpu_write(4'h0, 32'h0000_0000);
    sb.push_back(8'h99);
    cpu_write(4'h0, 32'h0000_0099);
    repeat (10) tick();
    tests_run++;
    if (tx !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_pre: got tx=%b required 0", tx);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (tx !== 1'b1 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_tx: got tx=%b irq=%b required tx=1 irq=1", tx, irq);
    end
    sel = 1'b1; we = 1'b0; addr = 4'h4;
    #1;
    tests_run++;
    if (rdata !== 32'h2) begin
      tests_failed++;
      $display("FAIL midrst_status: got %h required %h", rdata, 32'h2);
    end
    sel = 1'b0;
    sb.delete();
    repeat (2) tick();
    rst = 1'b0;
    fs = frames_started;
    repeat (60) tick();
    cpu_read(4'h8, d);
    tests_run++;
    if (frames_started !== fs || tx !== 1'b1 || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_residual: got starts=%0d tx=%b count=%h required starts=%0d tx=1 count=0",
               frames_started, tx, d, fs);
    end
  endtask

  task automatic test_reserved_unselected();
    logic [31:0] d;
    bit ok;
    sb.push_back(8'h3C);
    cpu_write(4'h0, 32'hFFFF_FF3C);
    sb.push_back(8'h81);
    cpu_write(4'h0, 32'hABCD_1281);
    cpu_read(4'hC, d);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL rsvd_read: got %h required %h", d, 32'h0);
    end
    tick();
    sel = 1'b0; we = 1'b0; addr = 4'h8;
    #1;
    tests_run++;
    if (rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL unsel_read: got %h required %h", rdata, 32'h0);
    end
    cpu_write(4'hC, 32'hFFFF_FFFF);
    cpu_read(4'h8, d);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL rsvd_count: got %h required %h", d, 32'h1);
    end
    cpu_read(4'h4, d);
    tests_run++;
    if (d !== 32'h4) begin
      tests_failed++;
      $display("FAIL rsvd_status: got %h required %h", d, 32'h4);
    end
    wait_idle(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL rsvd_drain: got queued=%0d required 0", sb.size());
    end
  endtask

  initial begin : main
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_full_pop_edge();
    test_reset_mid_frame();
    test_reserved_unselected();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
